multicycle_seq_ctrl: RTL

Parametrised multi-cycle sequencer and instruction decoder for the TiniSOC core. It generalises the fixed five-phase fetch/execute/writeback controller with:
- a configurable number of execute cycles;
- ready/wait handshakes to instruction and data memory;
- a memory phase that only load/store instructions enter;
- an external stall, a wait-timeout error state, and a retired-instruction counter.

It sits between the IM/DM ports, the register file, and the datapath muxes.

---
 rtl/multicycle_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_seq_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_seq_ctrl
//
// Multi-cycle sequencer and instruction decoder for the TiniSOC core. It walks
// each instruction through FETCH -> IWAIT -> LATCH -> EXEC (x EXEC_CYCLES) ->
// [MEM, loads/stores only] -> WB. It handshakes with instruction and data
// memory, can be frozen by an external stall, and drops into a sticky error
// state when a memory wait exceeds TIMEOUT cycles.
//
// Parameters
//   EXEC_CYCLES : cycles spent in EXEC per instruction (1..15)
//   TIMEOUT     : max wait cycles in IWAIT/MEM before ERR (0 disables)
//   CNT_W       : width of the retired-instruction counter
//
// Ports
//   clock, reset          : rising-edge clock, async active-high reset
//   ir                    : instruction word from IM, captured only in LATCH
//   IM_ready, DM_ready    : memory ready handshakes
//   stall                 : freezes state and counters
//   enable_pc .. enable_writeback : per-phase enables (Moore, from state)
//   IM_read / IM_write    : tied 1 / 0
//   DM_read / DM_write    : DM direction, only asserted in MEM
//   opcode, sub_opcode    : fields of the latched instruction
//   imm_reg_select, mux4to1_select, write_reg_select : datapath selects
//   state                 : current state encoding for debug
//   bus_error             : sticky wait-timeout flag
//   instr_count           : retired instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_seq_ctrl #(
  parameter int EXEC_CYCLES = 1,
  parameter int TIMEOUT     = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic             IM_ready,
  input  logic             DM_ready,
  input  logic             stall,
  output logic             enable_pc,
  output logic             IM_enable,
  output logic             enable_fetch,
  output logic             enable_execute,
  output logic             DM_enable,
  output logic             enable_writeback,
  output logic             IM_read,
  output logic             IM_write,
  output logic             DM_read,
  output logic             DM_write,
  output logic [5:0]       opcode,
  output logic [4:0]       sub_opcode,
  output logic [1:0]       imm_reg_select,
  output logic [1:0]       mux4to1_select,
  output logic [1:0]       write_reg_select,
  output logic [2:0]       state,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  // Opcode and sub-opcode codes shared with the rest of the core (def_op.v).
  localparam logic [5:0] OP_TY_BASE = 6'b100000;
  localparam logic [5:0] OP_ADDI    = 6'b101000;
  localparam logic [5:0] OP_ORI     = 6'b101100;
  localparam logic [5:0] OP_XORI    = 6'b101011;
  localparam logic [5:0] OP_MOVI    = 6'b100010;
  localparam logic [5:0] OP_LWI     = 6'b000010;
  localparam logic [5:0] OP_SWI     = 6'b001010;
  localparam logic [5:0] OP_TY_LS   = 6'b011100;

  localparam logic [4:0] SUB_SRLI   = 5'b01001;
  localparam logic [4:0] SUB_SLLI   = 5'b01000;
  localparam logic [4:0] SUB_ROTRI  = 5'b01011;

  localparam logic [7:0] LS_LW      = 8'b00000010;
  localparam logic [7:0] LS_SW      = 8'b00001010;

  localparam logic [3:0]  EXEC_LAST    = 4'(EXEC_CYCLES - 1);
  localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_IWAIT   = 3'd1,
    S_LATCH   = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_ERR     = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } memClass_t;

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [3:0]       execCnt_q, execCnt_d;
  logic [31:0]      waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0] instrCount_q, instrCount_d;
  logic             busError_q, busError_d;

  logic [5:0]       opField;
  logic [4:0]       subField;
  logic [1:0]       immSel, muxSel, wrSel;
  memClass_t        memClass;

  // Bits of the instruction word that no decode path looks at.
  logic             unusedIrBits;

  assign opField      = ir_q[30:25];
  assign subField     = ir_q[4:0];
  assign unusedIrBits = ^{ir_q[31], ir_q[24:8]};

  // Instruction decode from the latched word only, so the selects stay
  // stable for the whole instruction even while IM drives the next fetch.
  always_comb begin
    immSel   = 2'b00;
    muxSel   = 2'b00;
    wrSel    = 2'b00;
    memClass = CLS_NONE;
    case (opField)
      OP_TY_BASE: begin
        case (subField)
          SUB_SRLI, SUB_SLLI, SUB_ROTRI: immSel = 2'b01;
          default: ;
        endcase
      end
      OP_ADDI: begin
        immSel = 2'b01;
        muxSel = 2'b01;
      end
      OP_ORI, OP_XORI: begin
        immSel = 2'b01;
        muxSel = 2'b10;
      end
      OP_MOVI: begin
        immSel = 2'b01;
        muxSel = 2'b11;
        wrSel  = 2'b01;
      end
      OP_LWI: begin
        immSel   = 2'b10;
        wrSel    = 2'b10;
        memClass = CLS_LOAD;
      end
      OP_SWI: begin
        immSel   = 2'b10;
        memClass = CLS_STORE;
      end
      OP_TY_LS: begin
        if (ir_q[7:0] == LS_LW) begin
          immSel   = 2'b11;
          wrSel    = 2'b10;
          memClass = CLS_LOAD;
        end else if (ir_q[7:0] == LS_SW) begin
          immSel   = 2'b11;
          memClass = CLS_STORE;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic. A stall freezes everything, which also means a ready
  // pulse seen only during a stall is never consumed. The wait counter is
  // cleared on the transition into IWAIT/MEM and counts non-stalled cycles
  // with ready low; hitting TIMEOUT-1 on such a cycle means this is the
  // TIMEOUT-th miss, so the next edge lands in ERR.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    execCnt_d    = execCnt_q;
    waitCnt_d    = waitCnt_q;
    instrCount_d = instrCount_q;
    busError_d   = busError_q;

    if (state_q == S_ILLEGAL) begin
      state_d = S_FETCH;
    end else if (!stall) begin
      case (state_q)
        S_FETCH: begin
          state_d   = S_IWAIT;
          waitCnt_d = '0;
        end
        S_IWAIT: begin
          if (IM_ready) begin
            state_d = S_LATCH;
          end else if (TIMEOUT_EN && (waitCnt_q == TIMEOUT_LAST)) begin
            state_d    = S_ERR;
            busError_d = 1'b1;
          end else begin
            waitCnt_d = waitCnt_q + 32'd1;
          end
        end
        S_LATCH: begin
          ir_d      = ir;
          execCnt_d = '0;
          state_d   = S_EXEC;
        end
        S_EXEC: begin
          if (execCnt_q == EXEC_LAST) begin
            execCnt_d = '0;
            if (memClass != CLS_NONE) begin
              state_d   = S_MEM;
              waitCnt_d = '0;
            end else begin
              state_d = S_WB;
            end
          end else begin
            execCnt_d = execCnt_q + 4'd1;
          end
        end
        S_MEM: begin
          if (DM_ready) begin
            state_d = S_WB;
          end else if (TIMEOUT_EN && (waitCnt_q == TIMEOUT_LAST)) begin
            state_d    = S_ERR;
            busError_d = 1'b1;
          end else begin
            waitCnt_d = waitCnt_q + 32'd1;
          end
        end
        S_WB: begin
          instrCount_d = instrCount_q + 1'b1;
          state_d      = S_FETCH;
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Single state register bank; asynchronous reset puts every output at its
  // FETCH value immediately, even in the middle of a memory handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      ir_q         <= '0;
      execCnt_q    <= '0;
      waitCnt_q    <= '0;
      instrCount_q <= '0;
      busError_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      execCnt_q    <= execCnt_d;
      waitCnt_q    <= waitCnt_d;
      instrCount_q <= instrCount_d;
      busError_q   <= busError_d;
    end
  end

  // Phase enables decoded from the registered state. The "do something this
  // cycle" enables drop during a stall; the memory request lines keep their
  // level so an in-flight access is not withdrawn.
  always_comb begin
    enable_pc        = 1'b0;
    IM_enable        = 1'b0;
    enable_fetch     = 1'b0;
    enable_execute   = 1'b0;
    DM_enable        = 1'b0;
    DM_read          = 1'b0;
    DM_write         = 1'b0;
    enable_writeback = 1'b0;
    case (state_q)
      S_FETCH: begin
        enable_pc = !stall;
        IM_enable = 1'b1;
      end
      S_IWAIT: begin
        IM_enable = 1'b1;
      end
      S_LATCH: begin
        enable_fetch = !stall;
      end
      S_EXEC: begin
        enable_execute = !stall;
      end
      S_MEM: begin
        DM_enable = 1'b1;
        DM_read   = (memClass == CLS_LOAD);
        DM_write  = (memClass == CLS_STORE);
      end
      S_WB: begin
        enable_writeback = !stall && (memClass != CLS_STORE);
      end
      default: ;
    endcase
  end

  assign IM_read          = 1'b1;
  assign IM_write         = 1'b0;
  assign opcode           = opField;
  assign sub_opcode       = subField;
  assign imm_reg_select   = immSel;
  assign mux4to1_select   = muxSel;
  assign write_reg_select = wrSel;
  assign state            = state_q;
  assign bus_error        = busError_q;
  assign instr_count      = instrCount_q;

endmodule
